// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative radix-2 RV32M multiply/divide unit for the execute stage
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            n_rst,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            stall_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  logic [1:0]        state;
  logic [CW-1:0]     cnt;
  logic [2:0]        op;
  logic [XLEN-1:0]   opd;    // multiplicand for multiply, divisor for divide (magnitude)
  logic              neg;    // final result must be negated
  logic [2*XLEN-1:0] prod;   // product, or {remainder, dividend/quotient}
  logic [XLEN-1:0]   pend;   // result waiting to be presented in DONE
  logic [XLEN-1:0]   res;    // last delivered result

  logic              is_div_in;
  logic              sign_a_in;
  logic              sign_b_in;
  logic              neg_a;
  logic              neg_b;
  logic [XLEN-1:0]   mag_a;
  logic [XLEN-1:0]   mag_b;
  logic              div_zero;
  logic              div_ovf;
  logic              special;
  logic [XLEN-1:0]   special_val;
  logic              neg_in;

  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     div_shift;
  logic [XLEN:0]     div_diff;
  logic              div_ge;
  logic [2*XLEN-1:0] div_next;
  logic [2*XLEN-1:0] prod_next;
  logic [2*XLEN-1:0] prod_signed;
  logic [XLEN-1:0]   div_pick;
  logic [XLEN-1:0]   final_val;

  // Decode the incoming request: operand signedness, magnitudes and the divide corner cases.
  always_comb begin
    is_div_in   = op_i[2];
    sign_a_in   = (op_i == 3'd1) || (op_i == 3'd2) || (op_i == 3'd4) || (op_i == 3'd6);
    sign_b_in   = (op_i == 3'd1) || (op_i == 3'd4) || (op_i == 3'd6);
    neg_a       = sign_a_in & rs1_i[XLEN-1];
    neg_b       = sign_b_in & rs2_i[XLEN-1];
    mag_a       = neg_a ? (~rs1_i + 1'b1) : rs1_i;
    mag_b       = neg_b ? (~rs2_i + 1'b1) : rs2_i;
    div_zero    = is_div_in && (rs2_i == '0);
    div_ovf     = is_div_in && !op_i[0] && (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_i == '1);
    special     = div_zero | div_ovf;
    // Overflow DIV returns the most negative value, which is exactly rs1.
    if (div_zero)
      special_val = op_i[1] ? rs1_i : '1;
    else
      special_val = op_i[1] ? '0 : rs1_i;
    // Remainder takes the dividend sign; quotient and products take the XOR.
    if (is_div_in && op_i[1])
      neg_in = neg_a;
    else
      neg_in = neg_a ^ neg_b;
  end

  // One shift-add or restoring-subtract step, plus sign fix-up of the finished value.
  always_comb begin
    mul_sum     = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, opd} : '0);
    mul_next    = {mul_sum, prod[XLEN-1:1]};
    div_shift   = {prod[2*XLEN-1:XLEN], prod[XLEN-1]};
    div_diff    = div_shift - {1'b0, opd};
    div_ge      = ~div_diff[XLEN];
    div_next    = {(div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0]), prod[XLEN-2:0], div_ge};
    prod_next   = op[2] ? div_next : mul_next;
    prod_signed = neg ? (~prod_next + 1'b1) : prod_next;
    div_pick    = op[1] ? prod_next[2*XLEN-1:XLEN] : prod_next[XLEN-1:0];
    if (op[2])
      final_val = neg ? (~div_pick + 1'b1) : div_pick;
    else if (op == 3'd0)
      final_val = prod_signed[XLEN-1:0];
    else
      final_val = prod_signed[2*XLEN-1:XLEN];
  end

  // Control FSM and datapath registers; flush drops back to IDLE without touching results.
  always_ff @(posedge clk_i or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
      cnt   <= '0;
      op    <= '0;
      opd   <= '0;
      neg   <= 1'b0;
      prod  <= '0;
      pend  <= '0;
      res   <= '0;
    end else if (flush_i) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            op    <= op_i;
            neg   <= neg_in;
            cnt   <= '0;
            opd   <= is_div_in ? mag_b : mag_a;
            prod  <= {{XLEN{1'b0}}, (is_div_in ? mag_a : mag_b)};
            if (special) begin
              pend  <= special_val;
              state <= DONE;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          prod <= prod_next;
          if (cnt == LAST) begin
            pend  <= final_val;
            cnt   <= '0;
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          res   <= pend;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Status and result outputs; a flush in DONE hides the pending result.
  always_comb begin
    busy_o   = (state != IDLE);
    stall_o  = ((state == IDLE) && start_i) || (state == CALC);
    valid_o  = (state == DONE) && !flush_i;
    result_o = valid_o ? pend : res;
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit
module tb_muldiv_unit;

  logic        clk_i = 1'b0;
  logic        n_rst;
  logic        start_i;
  logic [2:0]  op_i;
  logic [31:0] rs1_i;
  logic [31:0] rs2_i;
  logic        flush_i;
  logic        busy_o;
  logic        stall_o;
  logic        valid_o;
  logic [31:0] result_o;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_res;

  muldiv_unit #(.XLEN(32)) dut (
    .clk_i    (clk_i),
    .n_rst    (n_rst),
    .start_i  (start_i),
    .op_i     (op_i),
    .rs1_i    (rs1_i),
    .rs2_i    (rs2_i),
    .flush_i  (flush_i),
    .busy_o   (busy_o),
    .stall_o  (stall_o),
    .valid_o  (valid_o),
    .result_o (result_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    longint ua;
    longint ub;
    logic [63:0] p;
    logic ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'({32'b0, a});
    ub  = longint'({32'b0, b});
    ovf = (a == 32'h80000000) && (b == 32'hFFFFFFFF);
    case (op)
      3'd0: begin p = 64'(ua * ub); return p[31:0]; end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub); return p[63:32]; end
      3'd3: begin p = 64'(ua * ub); return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (ovf) return 32'h80000000;
        p = 64'(sa / sb);
        return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        p = 64'(sa % sb);
        return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int lat_of(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2] && ((b == 0) || (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF)))
      return 1;
    return 33;
  endfunction

  // inj_kind: 0 none, 1 start with new operands at inj_cyc, 2 flush at inj_cyc
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int inj_cyc, input int inj_kind);
    int   lat;
    logic seen;
    logic [31:0] e;
    lat  = lat_of(op, a, b);
    seen = 1'b0;
    if (inj_kind != 2) exp_q.push_back(exp);
    op_i    = op;
    rs1_i   = a;
    rs2_i   = b;
    start_i = 1'b1;
    @(negedge clk_i);
    chk1("stall_c0", stall_o, 1'b1);
    @(posedge clk_i); #1;
    start_i = 1'b0;
    rs1_i   = ~a;
    rs2_i   = ~b;
    for (int k = 1; k <= 45 && !seen; k++) begin
      if (k == inj_cyc && inj_kind == 1) begin
        start_i = 1'b1;
        rs1_i   = 32'd5;
        rs2_i   = 32'd1;
      end
      if (k == inj_cyc && inj_kind == 2) flush_i = 1'b1;
      @(negedge clk_i);
      if (inj_kind != 2 && k <= lat) chk1("stall", stall_o, k < lat);
      if (inj_kind == 2 && k == inj_cyc + 1) begin
        chk1("flush_busy", busy_o, 1'b0);
        chk("flush_result", result_o, last_res);
      end
      if (valid_o) begin
        seen = 1'b1;
        chk_int("latency", k, (inj_kind == 2) ? 0 : lat);
        chk_int("queue_depth", exp_q.size(), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("result", result_o, e);
          last_res = e;
        end
      end
      @(posedge clk_i); #1;
      start_i = 1'b0;
      flush_i = 1'b0;
    end
    chk1("valid_seen", seen, inj_kind != 2);
    @(negedge clk_i);
    chk("hold_result", result_o, last_res);
    chk1("valid_pulse", valid_o, 1'b0);
    @(posedge clk_i); #1;
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    n_rst    = 1'b0;
    start_i  = 1'b0;
    op_i     = 3'd0;
    rs1_i    = '0;
    rs2_i    = '0;
    flush_i  = 1'b0;
    last_res = '0;
    #1;
    chk1("rst_busy", busy_o, 1'b0);
    chk1("rst_stall", stall_o, 1'b0);
    chk1("rst_valid", valid_o, 1'b0);
    chk("rst_result", result_o, 32'h0);
    repeat (2) @(posedge clk_i);
    #1;
    n_rst = 1'b1;

    run_op(3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 0, 0);
    run_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0, 0);
    run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 0, 0);
    run_op(3'd2, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 0, 0);
    run_op(3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 0, 0);
    run_op(3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 0, 0);
    run_op(3'd5, 32'd100,      32'd7,        32'd14,       0, 0);
    run_op(3'd7, 32'd100,      32'd7,        32'd2,        0, 0);
    run_op(3'd5, 32'h1234,     32'd0,        32'hFFFFFFFF, 0, 0);
    run_op(3'd6, 32'h1234,     32'd0,        32'h00001234, 0, 0);
    run_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0, 0);
    run_op(3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 0, 0);
    run_op(3'd4, 32'd1000,     32'd3,        32'd333,      10, 1);
    run_op(3'd4, 32'd1000,     32'd7,        32'd142,      15, 2);

    for (int i = 0; i < 6; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = (i == 2) ? 32'd0 : $urandom;
      run_op(rop, ra, rb, model(rop, ra, rb), 0, 0);
    end

    op_i    = 3'd0;
    rs1_i   = 32'h12345;
    rs2_i   = 32'h777;
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (19) @(posedge clk_i);
    #1;
    n_rst = 1'b0;
    #1;
    chk1("midrst_busy", busy_o, 1'b0);
    chk1("midrst_stall", stall_o, 1'b0);
    chk1("midrst_valid", valid_o, 1'b0);
    chk("midrst_result", result_o, 32'h0);
    @(posedge clk_i); #1;
    n_rst = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk_i);
      chk1("post_rst_valid", valid_o, 1'b0);
    end

    chk_int("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit inside the execute stage.
- Its result is selected onto alu_result ahead of the EX/MEM register, which feeds the memory stage.
- Accepts one operation at a time and holds the pipeline through stall_o until the result is ready.
- Radix-2: one bit per cycle, no DSP inference required.

Parameters:
- XLEN, 32, operand and result width; only 32 is verified.

Ports:
- clk_i  in  1  clock
- n_rst  in  1  reset, asynchronous, active-low
- start_i  in  1  request an operation; sampled only in IDLE
- op_i  in  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- rs1_i  in  XLEN  operand A (multiplicand / dividend)
- rs2_i  in  XLEN  operand B (multiplier / divisor)
- flush_i  in  1  abort the current operation (branch taken downstream)
- busy_o  out  1  state != IDLE
- stall_o  out  1  freeze upstream stages and the EX/MEM register
- valid_o  out  1  one-cycle pulse; result_o is valid in that cycle
- result_o  out  XLEN  operation result; held until the next accepted start

Behaviour:
- Reset (async, n_rst low):
  - state = IDLE; counter = 0; all datapath registers = 0.
  - busy_o = 0, stall_o = 0, valid_o = 0, result_o = 0.
- States: IDLE, CALC, DONE.
- IDLE:
  - start_i = 1 latches op_i, rs1_i, rs2_i at the clock edge.
  - Next state is CALC, or DONE for the special cases below.
- CALC:
  - counter runs 0..31, one iteration per cycle.
  - After the iteration at counter = 31, next state is DONE.
- DONE:
  - valid_o = 1 and result_o is updated for exactly one cycle.
  - Next state is IDLE.
- Latency, start edge = cycle 0: normal ops raise valid_o in cycle 33; special cases in cycle 1.
- stall_o = (IDLE & start_i) | CALC. It is low in DONE, so the pipeline advances in the same cycle valid_o is high.
- Multiply:
  - Operands are extended to 33 bits: signed for MULH (both operands), rs1 only for MULHSU, unsigned for MULHU/MUL.
  - Shift-add into a 64-bit product.
  - MUL returns product[31:0]; MULH/MULHSU/MULHU return product[63:32].
  - Signed handling may use magnitude multiplication plus a final conditional negate; the result must be bit-exact to the spec either way.
- Divide:
  - Restoring division on magnitudes.
  - Quotient sign = sign(rs1) XOR sign(rs2); remainder sign = sign(rs1). Both apply to signed ops only.
- Special cases (skip CALC; valid_o in cycle 1):
  - Divisor = 0: DIV/DIVU return 0xFFFFFFFF; REM/REMU return rs1.
  - Signed overflow (rs1 = 0x80000000, rs2 = 0xFFFFFFFF): DIV returns 0x80000000; REM returns 0.
- start_i while busy_o = 1: ignored. No queueing; operands are not resampled.
- flush_i = 1:
  - In any state, next state is IDLE and counter is cleared.
  - If the current state is DONE, valid_o is suppressed that cycle.
  - result_o keeps its previous value.
  - flush_i has priority over start_i in the same cycle; the new operation is not accepted.
- Reset mid-operation: returns immediately to the reset values; there is no residual valid_o after release.
- Operand inputs may change freely after acceptance; only the latched copies are used.

Test Plan:
- MUL, rs1 = 7, rs2 = 0xFFFFFFFD (−3), start at cycle 0 -> stall_o high cycles 0–32; valid_o pulse at cycle 33; result_o = 0xFFFFFFEB.
- MULHU, rs1 = rs2 = 0xFFFFFFFF -> result_o = 0xFFFFFFFE. MULH, same operands -> 0x00000000. MULHSU, rs1 = 0xFFFFFFFF, rs2 = 2 -> 0xFFFFFFFF.
- DIV, rs1 = 0xFFFFFFF9 (−7), rs2 = 2 -> result_o = 0xFFFFFFFD. REM, same operands -> 0xFFFFFFFF. DIVU, rs1 = 100, rs2 = 7 -> 14. REMU, same operands -> 2.
- DIVU, rs1 = 0x1234, rs2 = 0 -> valid_o at cycle 1, result_o = 0xFFFFFFFF. REM, same operands -> 0x1234. DIV, rs1 = 0x80000000, rs2 = 0xFFFFFFFF -> 0x80000000 at cycle 1.
- Start DIV, then at cycle 10 drive start_i = 1 with new operands -> ignored, original result at cycle 33. Start again, assert flush_i at cycle 15 -> busy_o low at cycle 16, no valid_o, result_o unchanged.
- Assert n_rst low at cycle 20 of an active MUL -> all outputs 0 immediately. After release with start_i = 0 -> no valid_o for 40 cycles.
